// File: rtl/onehot_sequencer.sv
// Registered N-to-2^N one-hot decoder with a rotating sequencer mode.
// A binary index is loaded through a valid/ready handshake and presented as a
// registered one-hot word. In rotate modes the hot bit walks one place per
// consumed beat, producing an endless stream until the next load.
module onehot_sequencer #(
    parameter int unsigned N = 2,
    localparam int unsigned OUT_W = 2 ** N
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     sel,
    input  logic [1:0]       mode,
    output logic [OUT_W-1:0] out,
    output logic [N-1:0]     idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             wrap
);

    typedef enum logic [1:0] {
        ModeHold  = 2'b00,
        ModeLeft  = 2'b01,
        ModeRight = 2'b10,
        ModeRsvd  = 2'b11
    } mode_e;

    logic [OUT_W-1:0] out_q, out_d;
    logic [N-1:0]     idx_q, idx_d;
    mode_e            mode_q, mode_d;
    logic             valid_q, valid_d;
    logic             wrap_q, wrap_d;

    logic load, consume;

    assign in_ready = !valid_q || out_ready;
    assign load     = in_valid && in_ready;
    assign consume  = valid_q && out_ready;

    // Next-state: a load always wins over a rotation step on the same cycle.
    always_comb begin
        idx_d   = idx_q;
        mode_d  = mode_q;
        valid_d = valid_q;
        wrap_d  = 1'b0;
        if (load) begin
            idx_d   = sel;
            mode_d  = mode_e'(mode);
            valid_d = 1'b1;
        end else if (consume) begin
            unique case (mode_q)
                ModeLeft: begin
                    idx_d  = idx_q + N'(1);
                    wrap_d = (idx_q == {N{1'b1}});
                end
                ModeRight: begin
                    idx_d  = idx_q - N'(1);
                    wrap_d = (idx_q == '0);
                end
                default: valid_d = 1'b0;
            endcase
        end
    end

    // The one-hot word is always re-derived from the next index, so out and idx
    // can never disagree.
    always_comb begin
        out_d = '0;
        for (int unsigned i = 0; i < OUT_W; i++) begin
            out_d[i] = (idx_d == N'(i));
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= OUT_W'(1);
            idx_q   <= '0;
            mode_q  <= ModeHold;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            out_q   <= out_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
        end
    end

    assign out       = out_q;
    assign idx       = idx_q;
    assign out_valid = valid_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_onehot_sequencer.sv
// Bench for onehot_sequencer: a table of per-cycle vectors on an N=2 instance
// plus hand-written sequences for rotate-right on N=3 and async reset.
module tb_onehot_sequencer;

    logic clk = 1'b0;
    logic rst_n;

    // N=2 instance signals
    logic       iv, ir, ov, ordy, wr;
    logic [1:0] sel, mode, idx;
    logic [3:0] out;

    // N=3 instance signals
    logic       iv3, ir3, ov3, ordy3, wr3;
    logic [2:0] sel3, idx3;
    logic [1:0] mode3;
    logic [7:0] out3;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       iv;
        logic [1:0] sel;
        logic [1:0] mode;
        logic       ordy;
        logic       exp_ir;
        logic [3:0] exp_out;
        logic [1:0] exp_idx;
        logic       exp_v;
        logic       exp_w;
    } vec_t;

    typedef struct {
        logic [7:0] out;
        logic [2:0] idx;
        logic       v;
        logic       w;
    } exp_t;

    vec_t vq[$];
    exp_t sb[$];

    onehot_sequencer #(.N(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv),
        .in_ready  (ir),
        .sel       (sel),
        .mode      (mode),
        .out       (out),
        .idx       (idx),
        .out_valid (ov),
        .out_ready (ordy),
        .wrap      (wr)
    );

    onehot_sequencer #(.N(3)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv3),
        .in_ready  (ir3),
        .sel       (sel3),
        .mode      (mode3),
        .out       (out3),
        .idx       (idx3),
        .out_valid (ov3),
        .out_ready (ordy3),
        .wrap      (wr3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic v_iv, input logic [1:0] v_sel, input logic [1:0] v_mode,
                       input logic v_ordy, input logic v_ir, input logic [3:0] v_out,
                       input logic [1:0] v_idx, input logic v_v, input logic v_w);
        vq.push_back('{v_iv, v_sel, v_mode, v_ordy, v_ir, v_out, v_idx, v_v, v_w});
    endtask

    // Apply one vector to the N=2 instance; called just after a posedge.
    task automatic run_vec(input int n, input vec_t v);
        exp_t e;
        iv   = v.iv;
        sel  = v.sel;
        mode = v.mode;
        ordy = v.ordy;
        sb.push_back('{{4'b0, v.exp_out}, {1'b0, v.exp_idx}, v.exp_v, v.exp_w});
        #1;
        chk($sformatf("row%0d in_ready", n), {31'b0, ir}, {31'b0, v.exp_ir});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk($sformatf("row%0d out", n), {28'b0, out}, {24'b0, e.out});
        chk($sformatf("row%0d idx", n), {30'b0, idx}, {29'b0, e.idx});
        chk($sformatf("row%0d out_valid", n), {31'b0, ov}, {31'b0, e.v});
        chk($sformatf("row%0d wrap", n), {31'b0, wr}, {31'b0, e.w});
    endtask

    // One cycle of the N=3 instance with an expected result.
    task automatic step3(input string name, input logic v_iv, input logic [2:0] v_sel,
                         input logic [1:0] v_mode, input logic [7:0] e_out,
                         input logic [2:0] e_idx, input logic e_w);
        exp_t e;
        iv3   = v_iv;
        sel3  = v_sel;
        mode3 = v_mode;
        ordy3 = 1'b1;
        sb.push_back('{e_out, e_idx, 1'b1, e_w});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({name, " out"}, {24'b0, out3}, {24'b0, e.out});
        chk({name, " idx"}, {29'b0, idx3}, {29'b0, e.idx});
        chk({name, " out_valid"}, {31'b0, ov3}, {31'b0, e.v});
        chk({name, " wrap"}, {31'b0, wr3}, {31'b0, e.w});
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        iv = 0; sel = 0; mode = 0; ordy = 0;
        iv3 = 0; sel3 = 0; mode3 = 0; ordy3 = 1;

        //   iv sel mode ordy ir  out      idx v  w
        add(1, 0, 0, 1, 1, 4'b0001, 0, 1, 0);   // decode loads back to back
        add(1, 1, 0, 1, 1, 4'b0010, 1, 1, 0);
        add(1, 2, 0, 1, 1, 4'b0100, 2, 1, 0);
        add(1, 3, 0, 1, 1, 4'b1000, 3, 1, 0);
        add(0, 0, 0, 1, 1, 4'b1000, 3, 0, 0);   // consume clears valid, out holds
        add(1, 2, 0, 0, 1, 4'b0100, 2, 1, 0);   // load under backpressure
        add(1, 1, 0, 0, 0, 4'b0100, 2, 1, 0);   // stalled: second load ignored
        add(1, 1, 0, 0, 0, 4'b0100, 2, 1, 0);
        add(1, 1, 0, 0, 0, 4'b0100, 2, 1, 0);
        add(0, 0, 0, 1, 1, 4'b0100, 2, 0, 0);   // consumed
        add(1, 2, 1, 1, 1, 4'b0100, 2, 1, 0);   // rotate-left from 2
        add(0, 0, 0, 1, 1, 4'b1000, 3, 1, 0);
        add(0, 0, 0, 1, 1, 4'b0001, 0, 1, 1);   // wrap 3 -> 0
        add(0, 0, 0, 1, 1, 4'b0010, 1, 1, 0);
        add(0, 0, 0, 1, 1, 4'b0100, 2, 1, 0);
        add(0, 0, 0, 1, 1, 4'b1000, 3, 1, 0);
        add(1, 1, 0, 1, 1, 4'b0010, 1, 1, 0);   // load at idx 3 beats rotation, no wrap
        add(0, 0, 0, 1, 1, 4'b0010, 1, 0, 0);
        add(0, 0, 0, 0, 1, 4'b0010, 1, 0, 0);   // idle, in_ready from !valid
        add(1, 3, 3, 1, 1, 4'b1000, 3, 1, 0);   // reserved mode decodes
        add(0, 0, 0, 1, 1, 4'b1000, 3, 0, 0);
        add(1, 0, 1, 1, 1, 4'b0001, 0, 1, 0);   // rotate-left from 0
        add(0, 0, 0, 0, 0, 4'b0001, 0, 1, 0);   // stalled rotate holds
        add(1, 2, 0, 0, 0, 4'b0001, 0, 1, 0);   // load ignored while stalled
        add(0, 0, 0, 1, 1, 4'b0010, 1, 1, 0);
        add(1, 3, 2, 1, 1, 4'b1000, 3, 1, 0);   // rotate-right from 3
        add(0, 0, 0, 1, 1, 4'b0100, 2, 1, 0);
        add(0, 0, 0, 1, 1, 4'b0010, 1, 1, 0);
        add(0, 0, 0, 1, 1, 4'b0001, 0, 1, 0);
        add(0, 0, 0, 1, 1, 4'b1000, 3, 1, 1);   // wrap 0 -> 3

        #12;
        chk("reset out", {28'b0, out}, 32'h1);
        chk("reset idx", {30'b0, idx}, 32'h0);
        chk("reset out_valid", {31'b0, ov}, 32'h0);
        chk("reset wrap", {31'b0, wr}, 32'h0);
        chk("reset out3", {24'b0, out3}, 32'h1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vq.size(); i++) begin
            run_vec(i, vq[i]);
        end

        // Async reset mid-rotation, between edges.
        ordy = 1'b1;
        iv   = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async out", {28'b0, out}, 32'h1);
        chk("async idx", {30'b0, idx}, 32'h0);
        chk("async out_valid", {31'b0, ov}, 32'h0);
        chk("async wrap", {31'b0, wr}, 32'h0);
        #3;
        rst_n = 1'b1;
        ordy = 1'b0;
        @(posedge clk);
        #1;
        chk("post-reset in_ready", {31'b0, ir}, 32'h1);
        chk("post-reset out_valid", {31'b0, ov}, 32'h0);
        chk("post-reset out", {28'b0, out}, 32'h1);

        // Rotate-right on N=3 through the 0 -> 7 wrap.
        step3("r3 load", 1'b1, 3'd1, 2'b10, 8'b0000_0010, 3'd1, 1'b0);
        step3("r3 s1", 1'b0, 3'd0, 2'b00, 8'b0000_0001, 3'd0, 1'b0);
        step3("r3 s2", 1'b0, 3'd0, 2'b00, 8'b1000_0000, 3'd7, 1'b1);
        step3("r3 s3", 1'b0, 3'd0, 2'b00, 8'b0100_0000, 3'd6, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
